fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the decode stage of the RV32I pipelined datapath under top.
//  Holds the fetch PC and issues requests on a variable-latency req/ready instruction-memory port.
//  Loads the IF/ID pipeline register.
//  Honours stall from the hazard unit and redirect (taken branch/jump) from EX.
// PARAMETERS
//  XLEN      32            data/address width
//  RESET_PC  32'h00000000  fetch PC after reset
//  NOP_INSTR 32'h00000013  bubble written to if_id_instr (addi x0,x0,0)
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     synchronous, active-low reset (0 = reset)
//  stall           in   1     hazard unit: hold IF/ID and fetch PC
//  redirect_valid  in   1     EX: control transfer taken, flush IF/ID
//  redirect_pc     in   XLEN  EX: target PC
//  imem_req        out  1     instruction read request
//  imem_addr       out  XLEN  word-aligned read address
//  imem_rdata      in   XLEN  instruction word, valid when imem_ready=1
//  imem_ready      in   1     memory completes the request this cycle
//  if_id_valid     out  1     IF/ID holds a real instruction
//  if_id_instr     out  XLEN  IF/ID instruction (NOP_INSTR when invalid)
//  if_id_pc        out  XLEN  PC of if_id_instr
//  pc_out          out  XLEN  current fetch PC (debug/monitor)
// BEHAVIOUR
//  Reset (reset==0 at posedge) applies in any state and mid-request:
//   - pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0
//   - buffer and pending redirect cleared; imem_req=0 while reset is low
//   - an in-flight memory response is ignored
//  Handshake rules:
//   - imem_addr stays stable while imem_req=1 and imem_ready=0
//   - a transfer completes on a posedge with imem_req=1 and imem_ready=1
//   - imem_ready is ignored while imem_req=0
//   - imem_addr[1:0] is always 0; redirect_pc[1:0] is forced to 0
//  FSM states: FETCH, HOLD, DROP.
//  FETCH:
//   - imem_req=1, imem_addr=pc
//   - on completion with stall=0: IF/ID <= {1, imem_rdata, pc}, pc += 4 (mod 2^XLEN, wraps)
//   - on completion with stall=1: word and pc go to the skid buffer, state -> HOLD
//  HOLD:
//   - imem_req=0, IF/ID unchanged
//   - when stall=0: IF/ID <= buffer, pc += 4, state -> FETCH
//  DROP:
//   - imem_req=1, imem_addr = stale address
//   - on completion: response discarded, pc <= pending target, state -> FETCH
//  Stall:
//   - while stall=1 and no redirect, all IF/ID outputs hold their values
//  Redirect (highest priority, wins over stall):
//   - IF/ID <= {0, NOP_INSTR, 0}; skid buffer discarded
//   - if a request is outstanding and incomplete (FETCH, imem_ready=0): latch target, state -> DROP
//   - else: pc <= target, state -> FETCH
//   - redirect while in DROP: overwrites the pending target
//  Latency and throughput:
//   - zero-wait memory (ready in the cycle of req): 1 instr/cycle
//   - first IF/ID valid at the 1st posedge after reset release with ready=1
//   - redirect to first valid target instruction: 1 cycle plus memory latency
// TESTING
//  1. Reset low 2 cycles, ready=1, mem[i]=i:
//     pc_out 0,4,8,...; if_id_valid rises at 1st edge; if_id_instr/pc = (0,0),(1,4),...
//  2. ready low 3 cycles at pc=8:
//     imem_addr held 8, imem_req held 1, IF/ID unchanged; on ready IF/ID=(mem[2],8), pc 12.
//  3. stall=1 2 cycles when the word at pc=12 completes:
//     IF/ID keeps the prior instr, imem_req=0 (HOLD); after stall drops IF/ID=(mem[3],12), pc 16.
//  4. redirect_valid=1, redirect_pc=0x41 with stall=1, ready=1:
//     next edge if_id_valid=0, if_id_instr=0x13; pc_out=0x40; next fetch addr 0x40.
//  5. redirect to 0x100 while the request at 0x20 is pending (ready=0):
//     addr held 0x20 until ready; response dropped, IF/ID stays invalid; next addr 0x100.
//  6. reset low during HOLD and again during DROP:
//     next edge pc_out=RESET_PC, if_id_valid=0, imem_req=0; normal fetch resumes from 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with req/ready imem port, skid buffer and IF/ID register
module fetch_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h13)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] pc_out
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
  state_t state;
  logic [XLEN-1:0] pc, skid, pend, tgt;
  assign tgt = redirect_pc & ~XLEN'(3);
  // pc is not advanced while a request is outstanding, so it doubles as the stale address in DROP
  assign imem_req = reset && state != HOLD;
  assign imem_addr = pc;
  assign pc_out = pc;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      skid <= NOP_INSTR;
      pend <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc <= '0;
      if (state != HOLD && !imem_ready) begin
        pend <= tgt;
        state <= DROP;
      end else begin
        pc <= tgt;
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          if (stall) begin
            skid <= imem_rdata;
            state <= HOLD;
          end else begin
            if_id_valid <= 1'b1;
            if_id_instr <= imem_rdata;
            if_id_pc <= pc;
            pc <= pc + XLEN'(4);
          end
        end
        HOLD: if (!stall) begin
          if_id_valid <= 1'b1;
          if_id_instr <= skid;
          if_id_pc <= pc;
          pc <= pc + XLEN'(4);
          state <= FETCH;
        end
        DROP: if (imem_ready) begin
          pc <= pend;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
